dffram_host_seq: RTL
====================

Name: dffram_host_seq

Overview:
Host-side sequencer that drives the 32x4 2R1W DFF RAM tile through its TinyTapeout pin interface (ui_in/uio_in in, uo_out/uio_oe back). Converts a valid/ready request stream (single write, or dual-port read) into pin-level cycles. Captures both read nibbles after a fixed latency and returns them on a valid/ready response stream. Used in the test harness and FPGA bring-up as the initiator end of the tile's pin protocol.

Parameters:
ADDR_W, 5, RAM address width (32 words)
DATA_W, 4, RAM word width
RD_LAT, 2, cycles from address drive to read data valid on uo_out; legal range 1..7

Ports:
clk  in  1  single clock, shared with the RAM tile
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1 = write, 0 = dual read
req_addr_a  in  ADDR_W  write address, or read address port A
req_addr_b  in  ADDR_W  read address port B (ignored on write)
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read response present
rsp_ready  in  1  response consumed when valid&ready
rsp_data_a  out  DATA_W  port A read data
rsp_data_b  out  DATA_W  port B read data
ram_ena  out  1  tile enable
ram_ui_in  out  8  drives tile ui_in
ram_uio_in  out  8  drives tile uio_in
ram_uo_out  in  8  tile uo_out
ram_uio_oe  in  8  tile uio_oe
err  out  1  sticky error flag

Behaviour:
- Pin map: ui_in[4:0] = addr A / waddr; ui_in[7] = we; uio_in[4:0] = addr B on read; uio_in[7:4] = wdata on write; uo_out[3:0] = data A; uo_out[7:4] = data B. Unused pin bits driven 0.
- Reset (async assert, sync release): req_ready=0, rsp_valid=0, rsp_data_*=0, ram_ui_in=0, ram_uio_in=0, ram_ena=0, err=0, FSM=IDLE. ram_ena rises the first cycle after release and stays 1.
- FSM states: IDLE, WR, RD_WAIT, RSP.
- IDLE: req_ready=1 (once ram_ena=1); pins idle (we=0, all 0).
  - Accepted write -> WR.
  - Accepted read -> RD_WAIT, latency counter loaded with RD_LAT-1.
- WR: we=1 with address/data for exactly one cycle; req_ready=0; -> IDLE. Back-to-back writes: one write per 2 cycles.
- RD_WAIT: addresses held on pins; counter decrements each cycle. At 0, capture uo_out[3:0]/[7:4] into rsp_data_a/b, set rsp_valid -> RSP. Accept-to-rsp_valid = RD_LAT+1 cycles.
- RSP: rsp_valid and rsp_data held stable until rsp_ready; pins return to idle; req_ready=0; on handshake -> IDLE, rsp_valid=0 next cycle.
- Read-after-write: a write is visible to a read issued the cycle after WR. No forwarding required.
- Same address on A and B: both ports return the same word.
- err set if ram_uio_oe != 8'h00 in any cycle with ram_ena=1 (bus contention: tile must keep uio as inputs); cleared only by reset.
- Reset mid-operation: in-flight request dropped, no response, pins forced idle immediately (asynchronous).

Optional Feature:
DFFRAM_HOST_WVERIFY_EN
- Defined: WR is followed by state WV: read of same address on port A, held RD_LAT cycles. If uo_out[3:0] != written data, err is set. No response emitted. Write throughput becomes one per RD_LAT+2 cycles.
- Undefined: WV absent; writes as above.

Decomposition:
- Package dffram_host_pkg: ADDR_W/DATA_W constants, FSM state enum, pin-bit position constants (WE_BIT, ADDRB_LSB, WDATA_LSB, RDATA_B_LSB).
- One sub-module: dffram_host_pinmux. Combinational state/fields -> ram_ui_in/ram_uio_in, plus uo_out nibble split. FSM, counter and capture stay in the top.

Test Plan:
- Reset then write addr 5 = 4'hA: ui_in = 8'h85 and uio_in = 8'hA0 for exactly one cycle; req_ready low that cycle.
- Read A=5, B=31 after writing 31 = 4'h3: rsp_valid exactly RD_LAT+1 cycles after accept; rsp_data_a = 4'hA, rsp_data_b = 4'h3.
- Hold rsp_ready=0 for 10 cycles: rsp_valid/data stable, req_ready=0, pins idle; release -> next request accepted the cycle after the handshake.
- Fill all 32 addresses with addr^4'hF, then dual-read pairs (n, 31-n): all values match; same-address pair returns equal nibbles.
- Force ram_uio_oe = 8'h01 for one cycle -> err=1 and stays 1 until rst_n pulse.
- Assert rst_n=0 mid RD_WAIT: outputs zero immediately, no rsp_valid after release. With DFFRAM_HOST_WVERIFY_EN, corrupt the tile model data -> err=1.

Source files
------------

// File: rtl/dffram_host_pkg.sv
// Shared widths, FSM encoding and TinyTapeout pin positions for the DFF RAM host sequencer.
package dffram_host_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 3;

  localparam int WE_BIT      = 7;
  localparam int ADDRA_LSB   = 0;
  localparam int ADDRB_LSB   = 0;
  localparam int WDATA_LSB   = 4;
  localparam int RDATA_A_LSB = 0;
  localparam int RDATA_B_LSB = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RSP     = 3'd3,
    ST_WV      = 3'd4
  } state_t;

endpackage

// File: rtl/dffram_host_pinmux.sv
// Maps sequencer state and latched request fields onto the tile's ui_in/uio_in pins
// and splits the tile's uo_out into the two read nibbles.
module dffram_host_pinmux
  import dffram_host_pkg::*;
(
  input  state_t              i_state,
  input  logic [ADDR_W-1:0]   i_addr_a,
  input  logic [ADDR_W-1:0]   i_addr_b,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [7:0]          i_uo_out,
  output logic [7:0]          o_ui_in,
  output logic [7:0]          o_uio_in,
  output logic [DATA_W-1:0]   o_rdata_a,
  output logic [DATA_W-1:0]   o_rdata_b
);

  // Pins are a pure function of the state register, so an async reset idles them at once.
  always_comb begin
    o_ui_in  = '0;
    o_uio_in = '0;
    case (i_state)
      ST_WR: begin
        o_ui_in[ADDRA_LSB +: ADDR_W]  = i_addr_a;
        o_ui_in[WE_BIT]               = 1'b1;
        o_uio_in[WDATA_LSB +: DATA_W] = i_wdata;
      end
      ST_RD_WAIT: begin
        o_ui_in[ADDRA_LSB +: ADDR_W]  = i_addr_a;
        o_uio_in[ADDRB_LSB +: ADDR_W] = i_addr_b;
      end
      ST_WV: begin
        o_ui_in[ADDRA_LSB +: ADDR_W]  = i_addr_a;
      end
      default: ;
    endcase
  end

  assign o_rdata_a = i_uo_out[RDATA_A_LSB +: DATA_W];
  assign o_rdata_b = i_uo_out[RDATA_B_LSB +: DATA_W];

endmodule

// File: rtl/dffram_host_seq.sv
// Host-side initiator for the 32x4 2R1W DFF RAM tile pin protocol.
// Optional write read-back check enabled by defining DFFRAM_HOST_WVERIFY_EN.
//
// state   | meaning
// IDLE    | pins idle, accepting requests once the tile is enabled
// WR      | one-cycle write strobe with address and data on the pins
// RD_WAIT | read addresses held while the latency counter runs down
// RSP     | captured read data offered until the consumer takes it
// WV      | (optional) read-back of the just-written word on port A
module dffram_host_seq
  import dffram_host_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic              ram_ena,
  output logic [7:0]        ram_ui_in,
  output logic [7:0]        ram_uio_in,
  input  logic [7:0]        ram_uo_out,
  input  logic [7:0]        ram_uio_oe,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ena;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr_a;
  logic [ADDR_W-1:0]   r_addr_b;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rsp_a;
  logic [DATA_W-1:0]   r_rsp_b;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_accept;
  logic                w_cnt_zero;
  logic                w_verify_fail;
  logic [DATA_W-1:0]   w_rdata_a;
  logic [DATA_W-1:0]   w_rdata_b;

  assign req_ready  = r_ena && (r_state == ST_IDLE);
  assign w_accept   = req_valid && req_ready;
  assign w_cnt_zero = (r_cnt == '0);
  assign rsp_valid  = (r_state == ST_RSP);
  assign rsp_data_a = r_rsp_a;
  assign rsp_data_b = r_rsp_b;
  assign ram_ena    = r_ena;
  assign err        = r_err;

`ifdef DFFRAM_HOST_WVERIFY_EN
  assign w_verify_fail = (r_state == ST_WV) && w_cnt_zero && (w_rdata_a != r_wdata);
`else
  assign w_verify_fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = req_write ? ST_WR : ST_RD_WAIT;
        end
      end
      ST_WR: begin
`ifdef DFFRAM_HOST_WVERIFY_EN
        w_state_nxt = ST_WV;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_RD_WAIT: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WV: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request fields stay latched after accept so the pinmux can hold them for the whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ena    <= 1'b0;
      r_err    <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_wdata  <= '0;
      r_rsp_a  <= '0;
      r_rsp_b  <= '0;
      r_cnt    <= '0;
    end else begin
      r_ena <= 1'b1;
      if ((r_ena && (ram_uio_oe != 8'h00)) || w_verify_fail) begin
        r_err <= 1'b1;
      end
      if (w_accept) begin
        r_addr_a <= req_addr_a;
        r_addr_b <= req_addr_b;
        r_wdata  <= req_wdata;
        r_cnt    <= CNT_INIT;
      end
      if (r_state == ST_WR) begin
        r_cnt <= CNT_INIT;
      end
      if (((r_state == ST_RD_WAIT) || (r_state == ST_WV)) && !w_cnt_zero) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if ((r_state == ST_RD_WAIT) && w_cnt_zero) begin
        r_rsp_a <= w_rdata_a;
        r_rsp_b <= w_rdata_b;
      end
    end
  end

  dffram_host_pinmux u_pinmux (
    .i_state   (r_state),
    .i_addr_a  (r_addr_a),
    .i_addr_b  (r_addr_b),
    .i_wdata   (r_wdata),
    .i_uo_out  (ram_uo_out),
    .o_ui_in   (ram_ui_in),
    .o_uio_in  (ram_uio_in),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b)
  );

endmodule
